// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam int          INST_W           = 32;

    // One delivered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Redirect targets are word aligned; the low two bits are ignored.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, count and head readout.
// Used both for delivered instructions and for the PC tag queue.
module fetch_fifo #(
    parameter  int W     = 64,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify push/pop; a push into a full FIFO is only legal alongside a pop.
    always_comb begin
        do_pop_s  = pop && (count_r != {CW{1'b0}});
        do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    end

    // Pointer and occupancy bookkeeping; flush empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/inst_fetch_chk.sv
// Protocol invariants of the fetch stage's internal queues.
module inst_fetch_chk #(
    parameter int CW = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          fifo_push,
    input logic          fifo_pop,
    input logic          fifo_full,
    input logic          tag_push,
    input logic          tag_pop,
    input logic          tag_full,
    input logic          tag_empty,
    input logic [CW-1:0] inflight,
    input logic [CW-1:0] tag_count
);

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        fifo_push |-> (!fifo_full || fifo_pop))
        else $error("instruction FIFO overflow");

    a_tag_no_overflow: assert property (@(posedge clk) disable iff (rst)
        tag_push |-> (!tag_full || tag_pop))
        else $error("tag queue overflow");

    a_tag_no_underflow: assert property (@(posedge clk) disable iff (rst)
        tag_pop |-> !tag_empty)
        else $error("response with no request in flight");

    a_inflight_match: assert property (@(posedge clk) disable iff (rst)
        inflight == tag_count)
        else $error("inflight counter disagrees with tag queue");

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, SRAM request issue, response buffering
// and redirect handling with discard of stale in-flight responses.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [31:0]       flush_pc,
    output logic              inst_req,
    output logic [31:0]       inst_addr,
    input  logic              inst_addr_ok,
    input  logic [INST_W-1:0] inst_rdata,
    input  logic              inst_data_ok,
    output logic              id_valid,
    output logic [INST_W-1:0] id_inst,
    output logic [31:0]       id_pc,
    input  logic              id_ready
);

    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   pc_r;
    logic          rst_sync_r;
    logic [CW-1:0] inflight_r;
    logic [CW-1:0] discard_r;

    logic [CW:0]   credit_sum_s;
    logic          inst_req_s;
    logic          accept_s;
    logic          drop_s;
    logic          fifo_push_s;
    logic          fifo_pop_s;

    fetch_entry_t  fifo_wr_s;
    fetch_entry_t  fifo_head_s;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;

    logic [31:0]   tag_head_s;
    logic [CW-1:0] tag_count_s;
    logic          tag_full_s;
    logic          tag_empty_s;

    // Issue credit, response routing and delivery handshake.
    always_comb begin
        credit_sum_s = {1'b0, inflight_r} + {1'b0, fifo_count_s};
        inst_req_s   = !rst_sync_r && (credit_sum_s < DEPTH_C) && !flush;
        accept_s     = inst_req_s && inst_addr_ok;
        // A response returning in a flush cycle belongs to the old stream.
        drop_s       = flush || (discard_r != {CW{1'b0}});
        fifo_push_s  = inst_data_ok && !drop_s;
        fifo_pop_s   = !fifo_empty_s && id_ready && !flush;
        fifo_wr_s    = '{pc: tag_head_s, inst: inst_rdata};
    end

    // PC, in-flight and discard bookkeeping; redirect takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            rst_sync_r <= 1'b1;
            inflight_r <= {CW{1'b0}};
            discard_r  <= {CW{1'b0}};
        end else begin
            rst_sync_r <= 1'b0;
            inflight_r <= inflight_r + CW'(accept_s) - CW'(inst_data_ok);
            if (flush) begin
                pc_r      <= align_pc(flush_pc);
                discard_r <= inflight_r - CW'(inst_data_ok);
            end else begin
                if (accept_s) begin
                    pc_r <= pc_r + 32'd4;
                end
                if (inst_data_ok && (discard_r != {CW{1'b0}})) begin
                    discard_r <= discard_r - CW'(1'b1);
                end
            end
        end
    end

    // PCs of requests awaiting their response, in request order.
    fetch_fifo #(.W(32), .DEPTH(DEPTH)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (accept_s),
        .push_data (pc_r),
        .pop       (inst_data_ok),
        .head      (tag_head_s),
        .count     (tag_count_s),
        .full      (tag_full_s),
        .empty     (tag_empty_s)
    );

    // Returned instructions waiting for decode.
    fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (fifo_push_s),
        .push_data (fifo_wr_s),
        .pop       (fifo_pop_s),
        .head      (fifo_head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    inst_fetch_chk #(.CW(CW)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .fifo_push (fifo_push_s),
        .fifo_pop  (fifo_pop_s),
        .fifo_full (fifo_full_s),
        .tag_push  (accept_s),
        .tag_pop   (inst_data_ok),
        .tag_full  (tag_full_s),
        .tag_empty (tag_empty_s),
        .inflight  (inflight_r),
        .tag_count (tag_count_s)
    );

    assign inst_req  = inst_req_s;
    assign inst_addr = pc_r;
    assign id_valid  = !fifo_empty_s;
    assign id_inst   = fifo_empty_s ? {INST_W{1'b0}} : fifo_head_s.inst;
    assign id_pc     = fifo_empty_s ? 32'h0 : fifo_head_s.pc;

endmodule
